// File: rtl/forwarding_source_pkg.sv
// Shared pipeline types for the MEM/WB forwarding source.
//   RegisterID_t        - architectural register index (x0..x31)
//   ForwardingSignals_t - MEM/WB rd, RegWrite, Value bundle consumed by EX
//   MemSlotState_t      - occupancy of the MEM slot
//   MemSlot_t           - contents of one pipeline slot (MEM or WB)
package forwarding_source_pkg;

    typedef logic [4:0] RegisterID_t;

    typedef struct packed {
        logic        MEM_RegWrite;
        RegisterID_t MEM_rd;
        logic [31:0] MEM_Value;
        logic        WB_RegWrite;
        RegisterID_t WB_rd;
        logic [31:0] WB_Value;
    } ForwardingSignals_t;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        READY     = 2'd1,
        LOAD_WAIT = 2'd2
    } MemSlotState_t;

    typedef struct packed {
        logic        valid;
        logic        RegWrite;
        RegisterID_t rd;
        logic [31:0] Value;
    } MemSlot_t;

    localparam int PerfCountW = 16;

    // A slot only advertises a write when it holds a result and the target is not x0.
    function automatic logic writesRd(input logic holdsResult, input logic regWrite,
                                      input RegisterID_t rd);
        return holdsResult && regWrite && (rd != '0);
    endfunction

endpackage

// File: rtl/forwarding_source_load_wait_timer.sv
// Load-wait timeout timer for the MEM slot.
// Loaded with LOAD_TIMEOUT when a load enters MEM, counts down on every
// waiting cycle without data, and flags a fault on the cycle that would take
// it to zero. LOAD_TIMEOUT = 0 loads zero, so the fault can never fire.
// Ports:
//   i_clk, i_rst_n - clock, async active-low reset
//   i_start        - a load is being captured into MEM this cycle
//   i_waiting      - MEM is in LOAD_WAIT
//   i_dataValid    - load data returned this cycle (beats the timeout)
//   o_fault        - combinational, high for the single timeout cycle
module forwarding_source_load_wait_timer #(
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_waiting,
    input  logic i_dataValid,
    output logic o_fault
);

    localparam int TimerW = (LOAD_TIMEOUT < 1) ? 1 : $clog2(LOAD_TIMEOUT + 1);
    localparam logic [TimerW-1:0] TimerLoad = TimerW'(LOAD_TIMEOUT);

    logic [TimerW-1:0] remaining;
    logic              countDown;

    assign countDown = i_waiting && !i_dataValid && (remaining != '0);
    assign o_fault   = countDown && (remaining == TimerW'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            remaining <= '0;
        end else if (i_start) begin
            remaining <= TimerLoad;
        end else if (countDown) begin
            remaining <= remaining - TimerW'(1);
        end
    end

endmodule

// File: rtl/forwarding_source.sv
// Producer end of the operand-forwarding interface: owns the MEM and WB result
// slots, tracks multi-cycle loads, drives the register-file write port and the
// forwarding bundle for EX.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// EMPTY     | MEM holds a bubble
// READY     | MEM holds a result (ALU value or returned load data)
// LOAD_WAIT | MEM holds a load waiting for data; MEM and WB are frozen
//
// Ports:
//   i_clk, i_rst_n            - clock, async active-low reset
//   i_stall                   - external stall, freezes MEM and WB
//   i_ex_*                    - EX-stage instruction (valid, RegWrite, MemRead, rd, Value)
//   i_id_rs1, i_id_rs2        - ID-stage sources for load-use detection
//   i_mem_rdata_valid/_rdata  - data-memory load response
//   o_ForwardingSignals       - MEM/WB forwarding bundle
//   o_wb_RegWrite/_rd/_Value  - register-file write port
//   o_MemWait                 - MEM waiting on load data
//   o_LoadUseStall            - load in EX feeds ID
//   o_LoadFault               - one-cycle load timeout pulse
//   o_WaitCycles              - LOAD_WAIT cycle counter
// Build option: define FWD_SOURCE_PERF_EN to implement o_WaitCycles as a
// 16-bit saturating counter; otherwise it is tied to zero.
module forwarding_source
    import forwarding_source_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_ex_valid,
    input  logic               i_ex_RegWrite,
    input  logic               i_ex_MemRead,
    input  RegisterID_t        i_ex_rd,
    input  logic [31:0]        i_ex_Value,
    input  RegisterID_t        i_id_rs1,
    input  RegisterID_t        i_id_rs2,
    input  logic               i_mem_rdata_valid,
    input  logic [31:0]        i_mem_rdata,
    output ForwardingSignals_t o_ForwardingSignals,
    output logic               o_wb_RegWrite,
    output RegisterID_t        o_wb_rd,
    output logic [31:0]        o_wb_Value,
    output logic               o_MemWait,
    output logic               o_LoadUseStall,
    output logic               o_LoadFault,
    output logic [15:0]        o_WaitCycles
);

    MemSlotState_t memState, memStateNext;
    MemSlot_t      memSlot, wbSlot;
    logic          adv;
    logic          exLoad;
    logic          loadFault;

    assign adv    = !i_stall && (memState != LOAD_WAIT);
    assign exLoad = i_ex_valid && i_ex_MemRead;

    forwarding_source_load_wait_timer #(
        .LOAD_TIMEOUT(LOAD_TIMEOUT)
    ) u_loadWaitTimer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (adv && exLoad),
        .i_waiting   (memState == LOAD_WAIT),
        .i_dataValid (i_mem_rdata_valid),
        .o_fault     (loadFault)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            memState <= EMPTY;
        end else begin
            memState <= memStateNext;
        end
    end

    // Load data completes a waiting load even under i_stall.
    always_comb begin
        memStateNext = memState;
        case (memState)
            EMPTY, READY: begin
                if (adv) begin
                    if (!i_ex_valid)       memStateNext = EMPTY;
                    else if (i_ex_MemRead) memStateNext = LOAD_WAIT;
                    else                   memStateNext = READY;
                end
            end
            LOAD_WAIT: begin
                if (i_mem_rdata_valid || loadFault) memStateNext = READY;
            end
            default: memStateNext = EMPTY;
        endcase
    end

    // memSlot.valid is kept equal to (memState == READY) so WB can take the
    // slot wholesale. A timed-out load becomes a READY slot that writes nothing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            memSlot <= '0;
            wbSlot  <= '0;
        end else if (adv) begin
            wbSlot           <= memSlot;
            memSlot.valid    <= i_ex_valid && !i_ex_MemRead;
            memSlot.RegWrite <= i_ex_valid && i_ex_RegWrite;
            memSlot.rd       <= i_ex_rd;
            memSlot.Value    <= i_ex_MemRead ? 32'd0 : i_ex_Value;
        end else if (memState == LOAD_WAIT) begin
            if (i_mem_rdata_valid) begin
                memSlot.valid <= 1'b1;
                memSlot.Value <= i_mem_rdata;
            end else if (loadFault) begin
                memSlot.valid    <= 1'b1;
                memSlot.RegWrite <= 1'b0;
            end
        end
    end

    always_comb begin
        o_ForwardingSignals              = '0;
        o_ForwardingSignals.MEM_RegWrite = writesRd(memState == READY, memSlot.RegWrite, memSlot.rd);
        o_ForwardingSignals.MEM_rd       = memSlot.rd;
        o_ForwardingSignals.MEM_Value    = memSlot.Value;
        o_ForwardingSignals.WB_RegWrite  = writesRd(wbSlot.valid, wbSlot.RegWrite, wbSlot.rd);
        o_ForwardingSignals.WB_rd        = wbSlot.rd;
        o_ForwardingSignals.WB_Value     = wbSlot.Value;
        o_MemWait                        = (memState == LOAD_WAIT);
    end

    assign o_wb_RegWrite  = o_ForwardingSignals.WB_RegWrite;
    assign o_wb_rd        = o_ForwardingSignals.WB_rd;
    assign o_wb_Value     = o_ForwardingSignals.WB_Value;
    assign o_LoadFault    = loadFault;
    assign o_LoadUseStall = exLoad && i_ex_RegWrite && (i_ex_rd != '0)
                            && ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));

`ifdef FWD_SOURCE_PERF_EN
    logic [PerfCountW-1:0] waitCycles;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            waitCycles <= '0;
        end else if ((memState == LOAD_WAIT) && (waitCycles != '1)) begin
            waitCycles <= waitCycles + PerfCountW'(1);
        end
    end

    assign o_WaitCycles = waitCycles;
`else
    assign o_WaitCycles = '0;
`endif

endmodule

// File: tb/tb_forwarding_source.sv
// Randomized scoreboard bench for forwarding_source (LOAD_TIMEOUT = 4).
module tb_forwarding_source;
    import forwarding_source_pkg::*;

    localparam int TO = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               stall, exValid, exRegWrite, exMemRead, rvalid;
    RegisterID_t        exRd, rs1, rs2;
    logic [31:0]        exValue, rdata;
    ForwardingSignals_t fwd;
    logic               wbRW, memWait, luStall, fault;
    RegisterID_t        wbRd;
    logic [31:0]        wbVal;
    logic [15:0]        waitCycles;

    forwarding_source #(.LOAD_TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
        .i_ex_valid(exValid), .i_ex_RegWrite(exRegWrite), .i_ex_MemRead(exMemRead),
        .i_ex_rd(exRd), .i_ex_Value(exValue), .i_id_rs1(rs1), .i_id_rs2(rs2),
        .i_mem_rdata_valid(rvalid), .i_mem_rdata(rdata),
        .o_ForwardingSignals(fwd), .o_wb_RegWrite(wbRW), .o_wb_rd(wbRd), .o_wb_Value(wbVal),
        .o_MemWait(memWait), .o_LoadUseStall(luStall), .o_LoadFault(fault),
        .o_WaitCycles(waitCycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        stall, exValid, exRegWrite, exMemRead, rvalid;
        bit [4:0]  exRd, rs1, rs2;
        bit [31:0] exValue, rdata;
    } stim_t;

    typedef struct {
        bit        memRW, memChk, memValChk, wbRW, wbChk, wbValChk;
        bit [4:0]  memRd, wbRd;
        bit [31:0] memVal, wbVal;
        bit        memWait, fault, luStall;
        bit [15:0] waitc;
    } exp_t;

    int    checks = 0;
    int    errors = 0;
    exp_t  expQ[$];
    stim_t cur;

    // Reference model of the two result slots, in terms of instructions.
    bit        mReady, mPending, mWrites, mValKnown;
    bit [4:0]  mRd;
    bit [31:0] mVal;
    int        age;
    bit        wValid, wWrites, wValKnown;
    bit [4:0]  wRd;
    bit [31:0] wVal;
    int        perf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic void modelReset();
        mReady = 0; mPending = 0; mWrites = 0; mValKnown = 0; mRd = 0; mVal = 0; age = 0;
        wValid = 0; wWrites = 0; wValKnown = 0; wRd = 0; wVal = 0; perf = 0;
    endfunction

    function automatic bit faultNow();
        return mPending && !cur.rvalid && (TO != 0) && (age + 1 == TO);
    endfunction

    function automatic exp_t calcExp();
        exp_t e;
        e.memRW     = mReady && mWrites && (mRd != 0);
        e.memChk    = mReady;
        e.memValChk = mReady && mValKnown;
        e.memRd     = mRd;
        e.memVal    = mVal;
        e.wbRW      = wValid && wWrites && (wRd != 0);
        e.wbChk     = wValid;
        e.wbValChk  = wValid && wValKnown;
        e.wbRd      = wRd;
        e.wbVal     = wVal;
        e.memWait   = mPending;
        e.fault     = faultNow();
        e.luStall   = cur.exValid && cur.exMemRead && cur.exRegWrite && (cur.exRd != 0)
                      && ((cur.exRd == cur.rs1) || (cur.exRd == cur.rs2));
`ifdef FWD_SOURCE_PERF_EN
        e.waitc     = 16'(perf);
`else
        e.waitc     = 16'd0;
`endif
        return e;
    endfunction

    function automatic void modelUpdate();
        bit adv = !cur.stall && !mPending;
        bit f = faultNow();
        bit wasPending = mPending;
        if (adv) begin
            wValid = mReady; wWrites = mWrites; wRd = mRd; wVal = mVal; wValKnown = mValKnown;
            if (!cur.exValid) begin
                mReady = 0; mPending = 0;
            end else if (cur.exMemRead) begin
                mReady = 0; mPending = 1; age = 0;
                mWrites = cur.exRegWrite; mRd = cur.exRd; mValKnown = 0;
            end else begin
                mReady = 1; mPending = 0;
                mWrites = cur.exRegWrite; mRd = cur.exRd; mVal = cur.exValue; mValKnown = 1;
            end
        end else if (mPending) begin
            if (cur.rvalid) begin
                mPending = 0; mReady = 1; mVal = cur.rdata; mValKnown = 1;
            end else if (f) begin
                mPending = 0; mReady = 1; mWrites = 0;
            end else begin
                age++;
            end
        end
        if (wasPending && perf < 65535) perf++;
    endfunction

    function automatic stim_t bubble();
        stim_t s;
        s.stall = 0; s.exValid = 0; s.exRegWrite = 0; s.exMemRead = 0; s.rvalid = 0;
        s.exRd = 0; s.rs1 = 0; s.rs2 = 0; s.exValue = 0; s.rdata = 0;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.stall      = ($urandom_range(0, 3) == 0);
        s.exValid    = ($urandom_range(0, 4) != 0);
        s.exMemRead  = ($urandom_range(0, 2) == 0);
        s.exRegWrite = ($urandom_range(0, 4) != 0);
        s.exRd       = 5'($urandom_range(0, 7));
        s.rs1        = 5'($urandom_range(0, 7));
        s.rs2        = 5'($urandom_range(0, 7));
        s.exValue    = $urandom;
        s.rdata      = $urandom;
        s.rvalid     = mPending ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    task automatic driveOnly(input stim_t s);
        cur = s;
        stall = s.stall; exValid = s.exValid; exRegWrite = s.exRegWrite; exMemRead = s.exMemRead;
        exRd = s.exRd; exValue = s.exValue; rs1 = s.rs1; rs2 = s.rs2;
        rvalid = s.rvalid; rdata = s.rdata;
    endtask

    task automatic apply(input stim_t s);
        driveOnly(s);
        expQ.push_back(calcExp());
    endtask

    task automatic tick();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_mem_rw"}, fwd.MEM_RegWrite, 0);
        chk({tag, "_mem_rd"}, fwd.MEM_rd, 0);
        chk({tag, "_mem_val"}, fwd.MEM_Value, 0);
        chk({tag, "_wb_rw"}, fwd.WB_RegWrite, 0);
        chk({tag, "_wb_rd"}, fwd.WB_rd, 0);
        chk({tag, "_wb_val"}, fwd.WB_Value, 0);
        chk({tag, "_port_rw"}, wbRW, 0);
        chk({tag, "_port_rd"}, wbRd, 0);
        chk({tag, "_port_val"}, wbVal, 0);
        chk({tag, "_memwait"}, memWait, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_lustall"}, luStall, 0);
        chk({tag, "_waitc"}, waitCycles, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                chk("mem_regwrite", fwd.MEM_RegWrite, e.memRW);
                if (e.memChk)    chk("mem_rd", fwd.MEM_rd, e.memRd);
                if (e.memValChk) chk("mem_value", fwd.MEM_Value, e.memVal);
                chk("wb_regwrite", fwd.WB_RegWrite, e.wbRW);
                chk("wb_port_regwrite", wbRW, e.wbRW);
                if (e.wbChk) begin
                    chk("wb_rd", fwd.WB_rd, e.wbRd);
                    chk("wb_port_rd", wbRd, e.wbRd);
                end
                if (e.wbValChk) begin
                    chk("wb_value", fwd.WB_Value, e.wbVal);
                    chk("wb_port_value", wbVal, e.wbVal);
                end
                chk("memwait", memWait, e.memWait);
                chk("loadfault", fault, e.fault);
                chk("loadusestall", luStall, e.luStall);
                chk("waitcycles", waitCycles, e.waitc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        stim_t s;
        int    expWait;
        modelReset();
        driveOnly(bubble());
        #12;
        checkAllZero("reset");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU write x5 visible on MEM then WB
        s = bubble(); s.exValid = 1; s.exRegWrite = 1; s.exRd = 5; s.exValue = 32'h0000_1234;
        apply(s); tick();
        apply(bubble()); #1;
        chk("t1_mem_rw", fwd.MEM_RegWrite, 1);
        chk("t1_mem_rd", fwd.MEM_rd, 5);
        chk("t1_mem_val", fwd.MEM_Value, 32'h0000_1234);
        tick();
        apply(bubble()); #1;
        chk("t1_wb_rw", wbRW, 1);
        chk("t1_wb_rd", wbRd, 5);
        chk("t1_wb_val", wbVal, 32'h0000_1234);
        tick();

        // load x7 with load-use hazard, data on third wait cycle
        s = bubble(); s.exValid = 1; s.exMemRead = 1; s.exRegWrite = 1; s.exRd = 7; s.rs2 = 7;
        apply(s); #1;
        chk("t2_lustall", luStall, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            s = bubble();
            if (i == 2) begin s.rvalid = 1; s.rdata = 32'hdead_beef; end
            apply(s); #1;
            chk("t2_memwait", memWait, 1);
            tick();
        end
        apply(bubble()); #1;
        chk("t2_memwait_end", memWait, 0);
        chk("t2_mem_val", fwd.MEM_Value, 32'hdead_beef);
        chk("t2_mem_rw", fwd.MEM_RegWrite, 1);
        tick();

        // write to x0 never flagged
        s = bubble(); s.exValid = 1; s.exRegWrite = 1; s.exRd = 0; s.exValue = 32'hffff_ffff;
        apply(s); tick();
        apply(bubble()); #1;
        chk("t3_mem_rw", fwd.MEM_RegWrite, 0);
        tick();
        apply(bubble()); #1;
        chk("t3_wb_rw", fwd.WB_RegWrite, 0);
        tick();

        // load timeout, late data ignored
        s = bubble(); s.exValid = 1; s.exMemRead = 1; s.exRegWrite = 1; s.exRd = 4;
        apply(s); tick();
        for (int i = 0; i < 4; i++) begin
            apply(bubble()); #1;
            chk("t4_fault", fault, (i == 3) ? 1 : 0);
            tick();
        end
        s = bubble(); s.stall = 1; s.rvalid = 1; s.rdata = 32'h1234_5678;
        apply(s); #1;
        chk("t4_memwait", memWait, 0);
        chk("t4_mem_rw", fwd.MEM_RegWrite, 0);
        tick();
        s = bubble(); s.stall = 1;
        apply(s); #1;
        chk("t4_mem_rw_late", fwd.MEM_RegWrite, 0);
        tick();

        // async reset while a load is pending
        s = bubble(); s.exValid = 1; s.exMemRead = 1; s.exRegWrite = 1; s.exRd = 3;
        apply(s); tick();
        apply(bubble()); tick();
        driveOnly(bubble());
        #1 rst_n = 1'b0;
        #1 checkAllZero("t5_reset");
        #5 rst_n = 1'b1;
        modelReset();
        tick();
        s = bubble(); s.rvalid = 1; s.rdata = 32'hcafe_f00d;
        apply(s); #1;
        chk("t5_memwait", memWait, 0);
        tick();
        apply(bubble()); #1;
        chk("t5_memwait_after", memWait, 0);
        chk("t5_mem_rw", fwd.MEM_RegWrite, 0);
        tick();

        // stall freezes a READY ALU result
        s = bubble(); s.exValid = 1; s.exRegWrite = 1; s.exRd = 9; s.exValue = 32'h0000_a5a5;
        apply(s); tick();
        for (int i = 0; i < 3; i++) begin
            s = randStim(); s.stall = 1;
            apply(s); #1;
            chk("t6_mem_rd", fwd.MEM_rd, 9);
            chk("t6_mem_val", fwd.MEM_Value, 32'h0000_a5a5);
            chk("t6_mem_rw", fwd.MEM_RegWrite, 1);
            tick();
        end
        apply(bubble()); tick();

        // five LOAD_WAIT cycles across two loads
        for (int l = 0; l < 2; l++) begin
            s = bubble(); s.exValid = 1; s.exMemRead = 1; s.exRegWrite = 1; s.exRd = 6;
            apply(s); tick();
            for (int i = 0; i < 3 - l; i++) begin
                s = bubble();
                if (i == 2 - l) begin s.rvalid = 1; s.rdata = $urandom; end
                apply(s); tick();
            end
        end
        apply(bubble()); #1;
`ifdef FWD_SOURCE_PERF_EN
        expWait = 5;
`else
        expWait = 0;
`endif
        chk("t6_waitcycles", waitCycles, 32'(expWait));
        tick();

        repeat (800) begin
            apply(randStim());
            tick();
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
